mem_arbiter: RTL and testbench

- Shares the single-port synchronous MEMOIRE block between two requesters: the 6502 CPU core and a byte-wide loader/debug port used to preload programs and inspect memory.
- The CPU is the default bus owner. The loader is granted single-byte transactions when the CPU is idle, or after a bounded starvation window.
- When the loader owns the bus, the CPU is stalled through CPU_RDY.
- Sits between the CPU core's address/data/read/write signals and MEMOIRE, inside the top-level CPU wrapper.

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port synchronous MEMOIRE block between the 6502 CPU core
// (default bus owner) and a byte-wide loader/debug port. The loader gets a
// single-byte transaction when the CPU is idle, or after the CPU has kept the
// bus busy for STARVE_LIMIT cycles while a loader request was pending. While
// the loader owns the bus the CPU is stalled through CPU_RDY.
//
// Each loader transaction walks CPU_OWN -> LDR_ACCESS -> LDR_DONE -> CPU_OWN:
// the CPU always gets at least one cycle between loader transactions.
//
// Parameters:
//   ADDR_W        address width of CPU, loader and memory ports
//   DATA_W        data width
//   STARVE_LIMIT  CPU-busy cycles a pending loader request may wait
//                 (0 = preempt the CPU immediately)
//
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   CPU_*               CPU core side; CPU_RDY = 0 stalls the core
//   LDR_*               loader side; REQ is a level, WE/ADDR/WDATA sampled at
//                       grant, ACK is a one-cycle completion pulse, RDATA holds
//                       the last loader read result
//   MEM_*               MEMOIRE side; MEM_RDATA valid the cycle after MEM_READ
//   GRANT_LDR           high while the loader owns the bus
//
// Optional feature (macro MEM_ARB_STATS_EN):
//   Adds LDR_XFER_COUNT, a saturating 16-bit count of completed loader
//   transactions, cleared by RESET. Arbitration timing is unaffected.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    // CPU core
    input  logic              CPU_READ,
    input  logic              CPU_WRITE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic [DATA_W-1:0] CPU_RDATA,
    output logic              CPU_RDY,
    // Loader / debug port
    input  logic              LDR_REQ,
    input  logic              LDR_WE,
    input  logic [ADDR_W-1:0] LDR_ADDR,
    input  logic [DATA_W-1:0] LDR_WDATA,
    output logic              LDR_ACK,
    output logic [DATA_W-1:0] LDR_RDATA,
    // MEMOIRE
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    // Status
    output logic              GRANT_LDR
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]       LDR_XFER_COUNT
`endif
);

    typedef enum logic [1:0] {
        CPU_OWN    = 2'd0,
        LDR_ACCESS = 2'd1,
        LDR_DONE   = 2'd2
    } state_t;

    // Counter must be able to hold STARVE_LIMIT itself; one bit minimum.
    localparam int               CNT_W   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    state_t            state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              ldr_we_q;
    logic [ADDR_W-1:0] ldr_addr_q;
    logic [DATA_W-1:0] ldr_wdata_q;

    logic cpu_busy;
    logic grant;

    assign cpu_busy = CPU_READ | CPU_WRITE;

    // The CPU access in the grant cycle still goes through; the loader takes
    // over from the following cycle.
    assign grant = (state == CPU_OWN) && LDR_REQ &&
                   (!cpu_busy || (starve_cnt == CNT_MAX));

    // -------------------------------------------------------------------------
    // Arbitration FSM, starvation counter and loader-side registers
    // -------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= CPU_OWN;
            starve_cnt  <= '0;
            ldr_we_q    <= 1'b0;
            ldr_addr_q  <= '0;
            ldr_wdata_q <= '0;
            LDR_ACK     <= 1'b0;
            LDR_RDATA   <= '0;
        end else begin
            LDR_ACK <= 1'b0;
            case (state)
                CPU_OWN: begin
                    if (grant) begin
                        ldr_we_q    <= LDR_WE;
                        ldr_addr_q  <= LDR_ADDR;
                        ldr_wdata_q <= LDR_WDATA;
                        starve_cnt  <= '0;
                        state       <= LDR_ACCESS;
                    end else if (!LDR_REQ) begin
                        starve_cnt <= '0;
                    end else if (cpu_busy && (starve_cnt < CNT_MAX)) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                LDR_ACCESS: begin
                    state <= LDR_DONE;
                end
                LDR_DONE: begin
                    // Read data from the LDR_ACCESS cycle is on MEM_RDATA now;
                    // capturing here makes it visible together with LDR_ACK.
                    if (!ldr_we_q) begin
                        LDR_RDATA <= MEM_RDATA;
                    end
                    LDR_ACK <= 1'b1;
                    state   <= CPU_OWN;
                end
                default: begin
                    state <= CPU_OWN;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory-side multiplexing
    // -------------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path through
    // this block leaves a value unassigned (which would infer a latch).
    always_comb begin
        MEM_READ  = 1'b0;
        MEM_WRITE = 1'b0;
        MEM_ADDR  = CPU_ADDR;
        MEM_WDATA = CPU_WDATA;
        CPU_RDY   = 1'b0;
        case (state)
            CPU_OWN: begin
                MEM_READ  = CPU_READ;
                MEM_WRITE = CPU_WRITE;
                CPU_RDY   = 1'b1;
            end
            LDR_ACCESS: begin
                MEM_ADDR  = ldr_addr_q;
                MEM_WDATA = ldr_wdata_q;
                MEM_WRITE = ldr_we_q;
                MEM_READ  = !ldr_we_q;
            end
            LDR_DONE: begin
                MEM_ADDR  = ldr_addr_q;
                MEM_WDATA = ldr_wdata_q;
            end
            default: begin
            end
        endcase
        // A reset landing mid-transaction must not let a write reach memory.
        if (RESET) begin
            MEM_READ  = 1'b0;
            MEM_WRITE = 1'b0;
            CPU_RDY   = 1'b0;
        end
    end

    assign CPU_RDATA = MEM_RDATA;
    assign GRANT_LDR = (state == LDR_ACCESS) || (state == LDR_DONE);

`ifdef MEM_ARB_STATS_EN
    // Counts on the edge that raises LDR_ACK, so it moves with the pulse.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            LDR_XFER_COUNT <= '0;
        end else if ((state == LDR_DONE) && (LDR_XFER_COUNT != 16'hFFFF)) begin
            LDR_XFER_COUNT <= LDR_XFER_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter. Two instances share all inputs:
//   dut_a  STARVE_LIMIT = 4
//   dut_b  STARVE_LIMIT = 0
// each with its own synchronous memory model (data valid the cycle after
// MEM_READ). Inputs change just after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        ldr_req, ldr_we;
    logic [15:0] ldr_addr;
    logic [7:0]  ldr_wdata;

    logic [7:0]  cpu_rdata_a, ldr_rdata_a, mem_wdata_a, mem_rdata_a;
    logic [15:0] mem_addr_a;
    logic        cpu_rdy_a, ldr_ack_a, mem_read_a, mem_write_a, grant_a;

    logic [7:0]  cpu_rdata_b, ldr_rdata_b, mem_wdata_b, mem_rdata_b;
    logic [15:0] mem_addr_b;
    logic        cpu_rdy_b, ldr_ack_b, mem_read_b, mem_write_b, grant_b;

`ifdef MEM_ARB_STATS_EN
    logic [15:0] xfer_count_a, xfer_count_b;
`endif

    bit [7:0] mem_a [0:65535];
    bit [7:0] mem_b [0:65535];

    int n_checks = 0;
    int n_bad    = 0;

    logic [15:0] b2b_addr [0:2] = '{16'h0500, 16'h0501, 16'h0502};
    logic [7:0]  b2b_data [0:2] = '{8'h11, 8'h22, 8'h33};

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(4)) dut_a (
        .CLK       (clk),
        .RESET     (rst),
        .CPU_READ  (cpu_read),
        .CPU_WRITE (cpu_write),
        .CPU_ADDR  (cpu_addr),
        .CPU_WDATA (cpu_wdata),
        .CPU_RDATA (cpu_rdata_a),
        .CPU_RDY   (cpu_rdy_a),
        .LDR_REQ   (ldr_req),
        .LDR_WE    (ldr_we),
        .LDR_ADDR  (ldr_addr),
        .LDR_WDATA (ldr_wdata),
        .LDR_ACK   (ldr_ack_a),
        .LDR_RDATA (ldr_rdata_a),
        .MEM_READ  (mem_read_a),
        .MEM_WRITE (mem_write_a),
        .MEM_ADDR  (mem_addr_a),
        .MEM_WDATA (mem_wdata_a),
        .MEM_RDATA (mem_rdata_a),
        .GRANT_LDR (grant_a)
`ifdef MEM_ARB_STATS_EN
        ,
        .LDR_XFER_COUNT (xfer_count_a)
`endif
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_LIMIT(0)) dut_b (
        .CLK       (clk),
        .RESET     (rst),
        .CPU_READ  (cpu_read),
        .CPU_WRITE (cpu_write),
        .CPU_ADDR  (cpu_addr),
        .CPU_WDATA (cpu_wdata),
        .CPU_RDATA (cpu_rdata_b),
        .CPU_RDY   (cpu_rdy_b),
        .LDR_REQ   (ldr_req),
        .LDR_WE    (ldr_we),
        .LDR_ADDR  (ldr_addr),
        .LDR_WDATA (ldr_wdata),
        .LDR_ACK   (ldr_ack_b),
        .LDR_RDATA (ldr_rdata_b),
        .MEM_READ  (mem_read_b),
        .MEM_WRITE (mem_write_b),
        .MEM_ADDR  (mem_addr_b),
        .MEM_WDATA (mem_wdata_b),
        .MEM_RDATA (mem_rdata_b),
        .GRANT_LDR (grant_b)
`ifdef MEM_ARB_STATS_EN
        ,
        .LDR_XFER_COUNT (xfer_count_b)
`endif
    );

    // Synchronous single-port memory models.
    always @(posedge clk) begin
        if (mem_write_a) mem_a[mem_addr_a] <= mem_wdata_a;
        if (mem_read_a)  mem_rdata_a <= mem_a[mem_addr_a];
        if (mem_write_b) mem_b[mem_addr_b] <= mem_wdata_b;
        if (mem_read_b)  mem_rdata_b <= mem_b[mem_addr_b];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One loader transaction on dut_a with the CPU idle; bounded wait for ACK.
    task automatic ldr_txn(input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata, output logic [7:0] rd);
        logic got_ack;
        got_ack   = 1'b0;
        ldr_we    = we;
        ldr_addr  = addr;
        ldr_wdata = wdata;
        ldr_req   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ldr_ack_a) begin
                got_ack = 1'b1;
                break;
            end
        end
        ldr_req = 1'b0;
        check("txn_ack_seen", got_ack, 1'b1);
        rd = ldr_rdata_a;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_ack;
        logic [7:0]  rd;

        rst = 1'b1;
        cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 16'h0200; cpu_wdata = 8'h00;
        ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = 16'h0000; ldr_wdata = 8'h00;

        // ---------------- reset ----------------
        @(negedge clk);
        check("rst_cpu_rdy_forced", cpu_rdy_a, 1'b0);
        check("rst_mem_read_forced", mem_read_a, 1'b0);
        check("rst_ldr_ack", ldr_ack_a, 1'b0);
        tick();
        @(negedge clk);
        check("rst_ldr_rdata", ldr_rdata_a, 8'h00);
        check("rst_grant", grant_a, 1'b0);
        tick();
        rst = 1'b0;

        // ---------------- preload via CPU writes ----------------
        cpu_read = 1'b0; cpu_write = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'hA9;
        @(negedge clk);
        check("cpu_wr_mem_write", mem_write_a, 1'b1);
        check("cpu_wr_mem_wdata", mem_wdata_a, 8'hA9);
        tick();
        cpu_addr = 16'h0400; cpu_wdata = 8'h11;
        tick();
        cpu_write = 1'b0;

        // ---------------- CPU read of 0x0200 ----------------
        cpu_read = 1'b1; cpu_addr = 16'h0200;
        @(negedge clk);
        check("cpu_rd_mem_read", mem_read_a, 1'b1);
        check("cpu_rd_mem_addr", mem_addr_a, 16'h0200);
        check("cpu_rd_rdy", cpu_rdy_a, 1'b1);
        check("cpu_rd_grant", grant_a, 1'b0);
        tick();
        cpu_read = 1'b0;
        @(negedge clk);
        check("cpu_rd_rdata", cpu_rdata_a, 8'hA9);
        check("cpu_rd_rdy2", cpu_rdy_a, 1'b1);
        tick();

        // ---------------- loader write, CPU idle ----------------
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0300; ldr_wdata = 8'h55;
        @(negedge clk);
        check("lw_own_grant", grant_a, 1'b0);
        check("lw_own_rdy", cpu_rdy_a, 1'b1);
        tick();
        // Drop the request and scramble fields: both must be ignored now.
        ldr_req = 1'b0; ldr_addr = 16'hFFFF; ldr_wdata = 8'h00;
        @(negedge clk);
        check("lw_acc_grant", grant_a, 1'b1);
        check("lw_acc_mem_write", mem_write_a, 1'b1);
        check("lw_acc_mem_read", mem_read_a, 1'b0);
        check("lw_acc_mem_addr", mem_addr_a, 16'h0300);
        check("lw_acc_mem_wdata", mem_wdata_a, 8'h55);
        check("lw_acc_rdy", cpu_rdy_a, 1'b0);
        check("lw_acc_ack", ldr_ack_a, 1'b0);
        tick();
        @(negedge clk);
        check("lw_done_grant", grant_a, 1'b1);
        check("lw_done_mem_write", mem_write_a, 1'b0);
        check("lw_done_rdy", cpu_rdy_a, 1'b0);
        check("lw_done_ack", ldr_ack_a, 1'b0);
        tick();
        @(negedge clk);
        check("lw_ack_pulse", ldr_ack_a, 1'b1);
        check("lw_ack_grant", grant_a, 1'b0);
        check("lw_ack_rdy", cpu_rdy_a, 1'b1);
        tick();
        cpu_read = 1'b1; cpu_addr = 16'h0300;
        @(negedge clk);
        check("lw_ack_single", ldr_ack_a, 1'b0);
        tick();
        cpu_read = 1'b0;
        @(negedge clk);
        check("lw_readback", cpu_rdata_a, 8'h55);
        tick();

        // ---------------- starvation, CPU busy, limit 4 ----------------
        cpu_read = 1'b1; cpu_addr = 16'h0200;
        ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 16'h0300; ldr_wdata = 8'h00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("starve_wait_grant", grant_a, 1'b0);
            check("starve_wait_rdy", cpu_rdy_a, 1'b1);
            tick();
        end
        @(negedge clk);                              // cycle 5: LDR_ACCESS
        check("starve_c5_rdy", cpu_rdy_a, 1'b0);
        check("starve_c5_mem_read", mem_read_a, 1'b1);
        check("starve_c5_mem_addr", mem_addr_a, 16'h0300);
        tick();
        @(negedge clk);                              // cycle 6: LDR_DONE
        check("starve_c6_rdy", cpu_rdy_a, 1'b0);
        check("starve_c6_mem_read", mem_read_a, 1'b0);
        tick();
        ldr_req = 1'b0;
        @(negedge clk);                              // cycle 7: ACK
        check("starve_c7_ack", ldr_ack_a, 1'b1);
        check("starve_c7_rdata", ldr_rdata_a, 8'h55);
        check("starve_c7_rdy", cpu_rdy_a, 1'b1);
        tick();

        // ---------------- back-to-back, limit 0, CPU busy ----------------
        reset_pulse();
        cpu_read = 1'b1; cpu_addr = 16'h0200;
        ldr_req = 1'b1; ldr_we = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b2b_own_rdy", cpu_rdy_b, 1'b1);
            check("b2b_own_ack", ldr_ack_b, (k != 0));
            n_ack += int'(ldr_ack_b);
            ldr_addr  = b2b_addr[k];
            ldr_wdata = b2b_data[k];
            tick();
            @(negedge clk);
            check("b2b_acc_rdy", cpu_rdy_b, 1'b0);
            check("b2b_acc_mem_write", mem_write_b, 1'b1);
            check("b2b_acc_cpu_blocked", mem_read_b, 1'b0);
            check("b2b_acc_mem_addr", mem_addr_b, b2b_addr[k]);
            n_ack += int'(ldr_ack_b);
            if (k == 2) ldr_req = 1'b0;
            tick();
            @(negedge clk);
            check("b2b_done_rdy", cpu_rdy_b, 1'b0);
            n_ack += int'(ldr_ack_b);
            tick();
        end
        @(negedge clk);
        check("b2b_last_ack", ldr_ack_b, 1'b1);
        check("b2b_last_rdy", cpu_rdy_b, 1'b1);
        n_ack += int'(ldr_ack_b);
        tick();
        @(negedge clk);
        check("b2b_idle_grant", grant_b, 1'b0);
        n_ack += int'(ldr_ack_b);
        check("b2b_ack_count", n_ack, 3);
        tick();
        cpu_addr = 16'h0502;
        tick();
        @(negedge clk);
        check("b2b_readback", cpu_rdata_b, 8'h33);
        tick();
        cpu_read = 1'b0;

        // ---------------- reset during LDR_ACCESS ----------------
        reset_pulse();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h0400; ldr_wdata = 8'hEE;
        @(negedge clk);
        check("rstacc_own_grant", grant_a, 1'b0);
        tick();
        rst = 1'b1; ldr_req = 1'b0;
        @(negedge clk);
        check("rstacc_mem_write", mem_write_a, 1'b0);
        check("rstacc_mem_read", mem_read_a, 1'b0);
        check("rstacc_rdy", cpu_rdy_a, 1'b0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstacc_after_grant", grant_a, 1'b0);
        check("rstacc_after_rdy", cpu_rdy_a, 1'b1);
        check("rstacc_after_ack", ldr_ack_a, 1'b0);
        tick();
        @(negedge clk);
        check("rstacc_after_ack2", ldr_ack_a, 1'b0);
        tick();
        cpu_read = 1'b1; cpu_addr = 16'h0400;
        tick();
        cpu_read = 1'b0;
        @(negedge clk);
        check("rstacc_mem_unchanged", cpu_rdata_a, 8'h11);
        tick();

        // ---------------- five loader transactions, read data hold ----------------
        reset_pulse();
        ldr_txn(1'b1, 16'h0600, 8'hA0, rd);
        ldr_txn(1'b0, 16'h0600, 8'h00, rd);
        check("seq_read_a0", rd, 8'hA0);
        ldr_txn(1'b1, 16'h0601, 8'hB1, rd);
        check("seq_rdata_held", rd, 8'hA0);
        ldr_txn(1'b1, 16'h0602, 8'hC2, rd);
        ldr_txn(1'b0, 16'h0601, 8'h00, rd);
        check("seq_read_b1", rd, 8'hB1);
`ifdef MEM_ARB_STATS_EN
        @(negedge clk);
        check("stats_count5", xfer_count_a, 16'd5);
        tick();
        reset_pulse();
        @(negedge clk);
        check("stats_count_rst", xfer_count_a, 16'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
